fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of `program_counter`. It takes the current PC, fetches the instruction word from instruction memory over a req/ack handshake with variable latency, and buffers fetched words in a small queue toward decode. It pulses `Pc_en` to advance the PC once per accepted fetch, and it supports pipeline flush on redirect and detection of misaligned PCs.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC to imem over req/ack, queues {pc, instr} toward decode, strobes Pc_en per accepted fetch.
// Latency: request one cycle after the IDLE decision, queue entry visible the cycle after ack; peak one word per 2 cycles.
// Backpressure: no request while the queue is full (registered count); decode pops with Instr_valid & Instr_ready.
module fetch_unit #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] Pc_i,
    output logic         Pc_en,
    input  logic         Flush,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] Instr_o,
    output logic [N-1:0] Instr_pc_o,
    output logic         Instr_valid,
    input  logic         Instr_ready,
    output logic         Misalign_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   addr_q;
    logic           load_addr;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_q;
    logic [N-1:0]   pc_mem    [DEPTH];
    logic [N-1:0]   instr_mem [DEPTH];
    logic           push, pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_addr) addr_q <= Pc_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        case (state_q)
            IDLE: begin
                // Registered count only: a same-cycle pop does not open a slot
                if (count_q < FULL && !Flush) begin
                    if (Pc_i[1:0] == 2'b00) begin
                        load_addr = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        state_d   = HALT;
                    end
                end
            end
            WAIT: begin
                if (imem_ack)   state_d = IDLE;
                else if (Flush) state_d = DROP;
            end
            DROP:    if (imem_ack) state_d = IDLE;
            HALT:    if (Flush)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req   = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr  = addr_q;
    assign Pc_en      = (state_q == WAIT) && imem_ack && !Flush;
    // The misalign flag is sticky exactly as long as the FSM sits in HALT
    assign Misalign_o = (state_q == HALT);

    assign push        = Pc_en;
    assign pop         = Instr_valid && Instr_ready && !Flush;
    assign Instr_valid = (count_q != '0);
    assign Instr_o     = instr_mem[rd_ptr];
    assign Instr_pc_o  = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= addr_q;
                instr_mem[wr_ptr] <= imem_rdata;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, single fetch, queue full, slow memory with flush, misalign, push+pop, async reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Pc_i;
    logic        Pc_en;
    logic        Flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_o;
    logic [31:0] Instr_pc_o;
    logic        Instr_valid;
    logic        Instr_ready;
    logic        Misalign_o;

    int errs   = 0;
    int checks = 0;

    fetch_unit #(.N(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .Pc_i(Pc_i), .Pc_en(Pc_en), .Flush(Flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .Instr_o(Instr_o), .Instr_pc_o(Instr_pc_o),
        .Instr_valid(Instr_valid), .Instr_ready(Instr_ready), .Misalign_o(Misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; Pc_i = 32'h5a5c; Flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; Instr_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_instr", Instr_o,              32'd0);
        chk("rst_ipc",   Instr_pc_o,           32'd0);
        chk("rst_valid", {31'd0, Instr_valid}, 32'd0);
        chk("rst_pcen",  {31'd0, Pc_en},       32'd0);
        chk("rst_mis",   {31'd0, Misalign_o},  32'd0);

        // Cycle k: release reset, IDLE decides to fetch 0x5a5c
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); chk("k_req", {31'd0, imem_req}, 32'd0);

        cyc(); imem_ack = 1'b1; imem_rdata = 32'h2108000a;       // k+1
        @(negedge clk);
        chk("f1_req",  {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr,         32'h5a5c);
        chk("f1_pcen", {31'd0, Pc_en},    32'd1);

        cyc(); imem_ack = 1'b0; Pc_i = 32'h5a60;                 // k+2
        @(negedge clk);
        chk("f1_valid", {31'd0, Instr_valid}, 32'd1);
        chk("f1_instr", Instr_o,              32'h2108000a);
        chk("f1_ipc",   Instr_pc_o,           32'h5a5c);
        chk("f1_req0",  {31'd0, imem_req},    32'd0);

        // Queue fills with decode stalled
        cyc(); imem_ack = 1'b1; imem_rdata = 32'h11111111;       // k+3
        @(negedge clk);
        chk("f2_addr", imem_addr,      32'h5a60);
        chk("f2_pcen", {31'd0, Pc_en}, 32'd1);

        cyc(); imem_ack = 1'b0; Pc_i = 32'h5a64;                 // k+4
        @(negedge clk); chk("full_req_a", {31'd0, imem_req}, 32'd0);
        cyc();                                                   // k+5
        @(negedge clk);
        chk("full_req_b", {31'd0, imem_req}, 32'd0);
        chk("full_head",  Instr_pc_o,        32'h5a5c);

        cyc(); Instr_ready = 1'b1;                               // k+6 pop
        @(negedge clk); chk("pop_req_a", {31'd0, imem_req}, 32'd0);
        cyc(); Instr_ready = 1'b0;                               // k+7 IDLE issues
        @(negedge clk);
        chk("pop_req_b",  {31'd0, imem_req}, 32'd0);
        chk("pop_head",   Instr_pc_o,        32'h5a60);
        chk("pop_hinstr", Instr_o,           32'h11111111);

        // Push and pop in the same cycle with one entry queued
        cyc(); imem_ack = 1'b1; imem_rdata = 32'h22222222; Instr_ready = 1'b1; // k+8
        @(negedge clk);
        chk("f3_addr", imem_addr,      32'h5a64);
        chk("f3_pcen", {31'd0, Pc_en}, 32'd1);

        cyc(); imem_ack = 1'b0; Pc_i = 32'h5a68;                 // k+9 pop again
        @(negedge clk);
        chk("pp_valid", {31'd0, Instr_valid}, 32'd1);
        chk("pp_ipc",   Instr_pc_o,           32'h5a64);
        chk("pp_instr", Instr_o,              32'h22222222);

        // Slow memory: flush in second WAIT cycle, ack in third
        cyc(); Instr_ready = 1'b0;                               // k+10 WAIT 1
        @(negedge clk);
        chk("pp_empty", {31'd0, Instr_valid}, 32'd0);
        chk("sl_req",   {31'd0, imem_req},    32'd1);
        chk("sl_addr",  imem_addr,            32'h5a68);

        cyc(); Flush = 1'b1;                                     // k+11 WAIT 2
        @(negedge clk);
        chk("sl_fl_pcen", {31'd0, Pc_en}, 32'd0);

        cyc(); Flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdead0001; // k+12 DROP
        @(negedge clk);
        chk("drop_req",  {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr,         32'h5a68);
        chk("drop_pcen", {31'd0, Pc_en},    32'd0);

        cyc(); imem_ack = 1'b0;                                  // k+13
        @(negedge clk);
        chk("drop_req0",  {31'd0, imem_req},    32'd0);
        chk("drop_empty", {31'd0, Instr_valid}, 32'd0);

        // Flush in the same cycle as ack
        cyc(); imem_ack = 1'b1; Flush = 1'b1; imem_rdata = 32'hdead0002; // k+14
        @(negedge clk);
        chk("fa_req",  {31'd0, imem_req}, 32'd1);
        chk("fa_pcen", {31'd0, Pc_en},    32'd0);

        // Misaligned PC
        cyc(); imem_ack = 1'b0; Flush = 1'b0; Pc_i = 32'h5a5e;  // k+15
        @(negedge clk);
        chk("fa_empty", {31'd0, Instr_valid}, 32'd0);
        chk("mis_req0", {31'd0, imem_req},    32'd0);

        cyc();                                                   // k+16
        @(negedge clk);
        chk("mis_set",  {31'd0, Misalign_o}, 32'd1);
        chk("mis_req1", {31'd0, imem_req},   32'd0);

        cyc(); Flush = 1'b1; Pc_i = 32'h5a60;                   // k+17
        @(negedge clk);
        chk("mis_hold", {31'd0, Misalign_o}, 32'd1);
        chk("mis_req2", {31'd0, imem_req},   32'd0);

        cyc(); Flush = 1'b0;                                     // k+18
        @(negedge clk); chk("mis_clr", {31'd0, Misalign_o}, 32'd0);

        cyc(); imem_ack = 1'b1; imem_rdata = 32'h33333333;       // k+19
        @(negedge clk);
        chk("rf_addr", imem_addr,      32'h5a60);
        chk("rf_pcen", {31'd0, Pc_en}, 32'd1);

        cyc(); imem_ack = 1'b0; Pc_i = 32'h5a64;                 // k+20
        @(negedge clk);
        chk("rf_instr", Instr_o,    32'h33333333);
        chk("rf_ipc",   Instr_pc_o, 32'h5a60);

        // Asynchronous reset pulse mid-WAIT
        cyc();                                                   // k+21
        chk("ar_req_pre", {31'd0, imem_req}, 32'd1);
        #1; reset = 1'b0;
        #1;
        chk("ar_req",   {31'd0, imem_req},    32'd0);
        chk("ar_valid", {31'd0, Instr_valid}, 32'd0);
        chk("ar_addr",  imem_addr,            32'd0);
        Pc_i = 32'h6000;
        #1; reset = 1'b1;

        cyc(); imem_ack = 1'b1; imem_rdata = 32'h44444444;       // k+22
        @(negedge clk);
        chk("ar2_req",  {31'd0, imem_req}, 32'd1);
        chk("ar2_addr", imem_addr,         32'h6000);
        chk("ar2_pcen", {31'd0, Pc_en},    32'd1);

        cyc(); imem_ack = 1'b0; Pc_i = 32'h6004;                 // k+23
        @(negedge clk);
        chk("ar2_instr", Instr_o,    32'h44444444);
        chk("ar2_ipc",   Instr_pc_o, 32'h6000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
